// File: rtl/max_hold_pkg.sv
// Shared compare-mode constants and helpers for the windowed max/min hold block.
package max_hold_pkg;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    // Strict a > b for operands of 'width' bits, zero-extended into 64 bits.
    // Signed order is obtained by flipping the sign bit and comparing unsigned.
    function automatic logic gt(input logic [63:0] a, input logic [63:0] b,
                                input int unsigned width, input logic mode);
        logic [63:0] flip;
        if (mode == CMP_SIGNED) begin
            flip = 64'd1 << (width - 32'd1);
        end else begin
            flip = 64'd0;
        end
        return (a ^ flip) > (b ^ flip);
    endfunction

    function automatic int cnt_width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max_hold_window_cmp.sv
// Combinational compare/select; ties select b (a_wins only on strict a > b).
module max_hold_cmp
    import max_hold_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic                  mode,
    output logic [data_width-1:0] larger,
    output logic [data_width-1:0] smaller,
    output logic                  a_wins
);

    // Strict compare under the selected ordering, then steer both operands.
    always_comb begin
        a_wins = gt(64'(a), 64'(b), data_width, mode);
        if (a_wins) begin
            larger  = a;
            smaller = b;
        end else begin
            larger  = b;
            smaller = a;
        end
    end

endmodule

// File: rtl/max_hold_window.sv
// Windowed running max/min hold with per-window compare mode.
// Optional first-occurrence index outputs: define MAX_HOLD_INDEX_EN.
module max_hold_window
    import max_hold_pkg::*;
#(
    parameter int data_width = 8,
    parameter int window_len = 16,
    localparam int cnt_width = cnt_width_of(window_len)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  data_valid,
    input  logic [data_width-1:0] data,
    input  logic                  signed_mode,
    output logic [data_width-1:0] max,
    output logic [data_width-1:0] min,
    output logic [cnt_width-1:0]  count,
    output logic [data_width-1:0] window_max,
    output logic [data_width-1:0] window_min,
    output logic                  window_valid
`ifdef MAX_HOLD_INDEX_EN
    ,
    output logic [cnt_width-1:0]  max_index,
    output logic [cnt_width-1:0]  min_index,
    output logic [cnt_width-1:0]  window_max_index,
    output logic [cnt_width-1:0]  window_min_index
`endif
);

    logic                  mode_r;
    logic                  accept_s;
    logic                  first_s;
    logic                  last_s;
    logic                  above_max_s;
    logic                  below_min_s;
    logic [data_width-1:0] larger_s;
    logic [data_width-1:0] cmp_smaller_unused_s;
    logic [data_width-1:0] max_next_s;
    logic [data_width-1:0] min_next_s;
    logic [cnt_width-1:0]  count_next_s;

    max_hold_cmp #(.data_width(data_width)) u_cmp (
        .a       (data),
        .b       (max),
        .mode    (mode_r),
        .larger  (larger_s),
        .smaller (cmp_smaller_unused_s),
        .a_wins  (above_max_s)
    );

    // Next-state values for the running extremes and the window position.
    always_comb begin
        accept_s    = data_valid & ~clear;
        first_s     = (count == cnt_width'(0));
        last_s      = (count == cnt_width'(window_len - 1));
        below_min_s = gt(64'(min), 64'(data), data_width, mode_r);
        if (first_s) begin
            max_next_s = data;
            min_next_s = data;
        end else begin
            max_next_s = larger_s;
            min_next_s = below_min_s ? data : min;
        end
        // Wrap explicitly so non-power-of-two windows never run to 2^cnt_width.
        if (last_s) begin
            count_next_s = cnt_width'(0);
        end else begin
            count_next_s = count + cnt_width'(1);
        end
    end

    // Running and per-window result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_r       <= CMP_UNSIGNED;
            max          <= {data_width{1'b0}};
            min          <= {data_width{1'b0}};
            count        <= cnt_width'(0);
            window_max   <= {data_width{1'b0}};
            window_min   <= {data_width{1'b0}};
            window_valid <= 1'b0;
        end else if (clear) begin
            max          <= {data_width{1'b0}};
            min          <= {data_width{1'b0}};
            count        <= cnt_width'(0);
            window_valid <= 1'b0;
        end else if (accept_s) begin
            max          <= max_next_s;
            min          <= min_next_s;
            count        <= count_next_s;
            window_valid <= last_s;
            if (first_s) begin
                mode_r <= signed_mode;
            end
            if (last_s) begin
                window_max <= max_next_s;
                window_min <= min_next_s;
            end
        end else begin
            window_valid <= 1'b0;
        end
    end

`ifdef MAX_HOLD_INDEX_EN
    logic [cnt_width-1:0] max_index_next_s;
    logic [cnt_width-1:0] min_index_next_s;

    // Only a strictly better sample moves the index, so ties keep the earlier one.
    always_comb begin
        if (first_s) begin
            max_index_next_s = cnt_width'(0);
            min_index_next_s = cnt_width'(0);
        end else begin
            max_index_next_s = above_max_s ? count : max_index;
            min_index_next_s = below_min_s ? count : min_index;
        end
    end

    // Index registers follow the same accept/clear/window timing as the values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            max_index        <= cnt_width'(0);
            min_index        <= cnt_width'(0);
            window_max_index <= cnt_width'(0);
            window_min_index <= cnt_width'(0);
        end else if (clear) begin
            max_index <= cnt_width'(0);
            min_index <= cnt_width'(0);
        end else if (accept_s) begin
            max_index <= max_index_next_s;
            min_index <= min_index_next_s;
            if (last_s) begin
                window_max_index <= max_index_next_s;
                window_min_index <= min_index_next_s;
            end
        end
    end
`endif

endmodule
